dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter PA, default 22: physical address width in bits.
REQ-002 SHALL have parameter LINE_LENGTH, default 4: cache line length in bytes; NIB = 2*LINE_LENGTH nibbles per line.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1: CPU data access valid this cycle.
REQ-006 SHALL have port hit, input, 1: cache hit for the current access.
REQ-007 SHALL have port push, input, 1: the indexed line is valid, dirty and mismatched, so writeback is required.
REQ-008 SHALL have port fault, input, 1: the current access faulted; no miss is started.
REQ-009 SHALL have port miss_tag, input, PA-log2(LINE_LENGTH): line address of the requested line.
REQ-010 SHALL have port victim_tag, input, PA-log2(LINE_LENGTH): line address of the dirty victim line.
REQ-011 SHALL have port dwrite, input, 4: nibble read out of the cache during the rstrobe_d burst.
REQ-012 SHALL have port rstrobe_d, output, 1: cache read-burst strobe.
REQ-013 SHALL have port wstrobe_d, output, 1: cache write-burst strobe.
REQ-014 SHALL have port dread, output, 4: nibble written into the cache during the wstrobe_d burst.
REQ-015 SHALL have port stall, output, 1: CPU must hold the access.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when a miss completes.
REQ-017 SHALL have port mem_valid, output, 1: nibble request to the external memory.
REQ-018 SHALL have port mem_we, output, 1: 1 = nibble write, 0 = nibble read.
REQ-019 SHALL have port mem_addr, output, PA+1: nibble address, {line address, nibble index[log2(NIB)-1:0]}.
REQ-020 SHALL have port mem_wdata, output, 4: write nibble.
REQ-021 SHALL have port mem_rdy, input, 1: memory accepts the request this cycle.
REQ-022 SHALL have port mem_rvalid, input, 1: read nibble is returned this cycle.
REQ-023 SHALL have port mem_rdata, input, 4: returned read nibble.

Function
REQ-024 SHALL implement states IDLE, WB_CAP, WB_MEM, FILL_MEM, FILL_WR, DONE.
REQ-025 SHALL, in IDLE with req && !hit && !fault, go to WB_CAP if push, else to FILL_MEM; with req && (hit || fault), stay in IDLE.
REQ-026 SHALL latch miss_tag and victim_tag on leaving IDLE, and hold them until the next return to IDLE.
REQ-027 SHALL, in WB_CAP, assert rstrobe_d for exactly NIB consecutive cycles k = 0..NIB-1, store dwrite into buffer entry k, then go to WB_MEM.
REQ-028 SHALL, in WB_MEM, write buffer entries 0..NIB-1 in order with mem_we = 1 and mem_addr = {victim_tag, k}, advancing k only on mem_valid && mem_rdy, then go to FILL_MEM.
REQ-029 SHALL hold mem_valid, mem_addr, mem_we and mem_wdata stable while mem_valid && !mem_rdy.
REQ-030 SHALL, in FILL_MEM, issue reads with mem_addr = {miss_tag, k}, keep at most one read outstanding, store mem_rdata into buffer entry k on mem_rvalid, and go to FILL_WR after entry NIB-1 is stored.
REQ-031 SHALL deassert mem_valid while a read is outstanding.
REQ-032 SHALL ignore mem_rvalid when no read is outstanding.
REQ-033 SHALL, in FILL_WR, assert wstrobe_d for exactly NIB consecutive cycles with dread = buffer entry k in cycle k, then go to DONE; strobe bursts SHALL NOT contain gaps.
REQ-034 SHALL, in DONE, assert done for one cycle and return to IDLE.
REQ-035 SHALL drive stall = (req && !hit && !fault) in IDLE, and stall = 1 in every other state, including DONE.
REQ-036 SHALL use a nibble counter of log2(NIB) bits that is cleared on every state transition; it SHALL NOT wrap within a phase.
REQ-037 SHALL never assert rstrobe_d and wstrobe_d in the same cycle.
REQ-038 SHALL never assert mem_valid outside WB_MEM and FILL_MEM.
REQ-039 SHALL ignore changes on req, hit, push and fault outside IDLE.

Reset
REQ-040 SHALL, while reset = 1, force state IDLE, counter 0, and stall, done, rstrobe_d, wstrobe_d and mem_valid all 0, with mem_we, mem_addr, mem_wdata and dread 0.
REQ-041 SHALL, on reset mid-operation (any state, including mid-burst), abort immediately without completing the burst; the outstanding read is dropped and any late mem_rvalid is ignored.

Verification
REQ-042 SHALL pass: req=1, hit=1 -> stall=0; mem_valid, rstrobe_d and wstrobe_d stay 0.
REQ-043 SHALL pass: clean miss, miss_tag=0x1234, mem_rdy=1, rvalid 2 cycles after each accept with data k+1 -> reads issued to nibble addresses {0x1234,0..7}; then 8 contiguous wstrobe_d cycles with dread = 1..8; then a done pulse; stall=1 throughout.
REQ-044 SHALL pass: dirty miss, victim_tag=0x0ABC, dwrite = 0xF-k -> 8 contiguous rstrobe_d cycles; then writes to {0x0ABC,0..7} with data F..8, all before the first fill read.
REQ-045 SHALL pass: mem_rdy toggled pseudo-randomly -> mem_addr, mem_we and mem_wdata stable while stalled; no nibble is skipped or duplicated.
REQ-046 SHALL pass: reset asserted on the 4th wstrobe_d cycle -> all outputs 0 asynchronously; next miss restarts cleanly with a full 8-cycle burst.
REQ-047 SHALL pass: req=1, hit=0, fault=1 -> stall=0; no state change.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Data-cache miss controller: optional dirty-line writeback, then line fill.
// Nibble-serial memory port and nibble-serial cache-array bursts.
module dcache_ctrl #(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  localparam int NIB        = 2 * LINE_LENGTH,
  localparam int CW         = $clog2(NIB),
  localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          hit,
  input  logic          push,
  input  logic          fault,
  input  logic [TW-1:0] miss_tag,
  input  logic [TW-1:0] victim_tag,
  input  logic [3:0]    dwrite,
  output logic          rstrobe_d,
  output logic          wstrobe_d,
  output logic [3:0]    dread,
  output logic          stall,
  output logic          done,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [PA:0]   mem_addr,
  output logic [3:0]    mem_wdata,
  input  logic          mem_rdy,
  input  logic          mem_rvalid,
  input  logic [3:0]    mem_rdata,
  output logic [2:0]    state_dbg
);

  // Memory handshake: a nibble request transfers on a rising edge where
  // mem_valid && mem_rdy; while mem_valid && !mem_rdy the request (mem_we,
  // mem_addr, mem_wdata) is held unchanged. Read data returns later as a
  // one-cycle mem_rvalid, with at most one read outstanding.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_CAP   = 3'd1,
    WB_MEM   = 3'd2,
    FILL_MEM = 3'd3,
    FILL_WR  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rd_pend;
  logic [TW-1:0]   miss_tag_q;
  logic [TW-1:0]   victim_tag_q;
  logic [3:0]      line_buf [NIB];
  logic            last;

  assign last      = (cnt == CW'(NIB - 1));
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_pend      <= 1'b0;
      miss_tag_q   <= '0;
      victim_tag_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit && !fault) begin
            miss_tag_q   <= miss_tag;
            victim_tag_q <= victim_tag;
            cnt          <= '0;
            state        <= push ? WB_CAP : FILL_MEM;
          end
        end
        WB_CAP: begin
          if (last) begin
            cnt   <= '0;
            state <= WB_MEM;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WB_MEM: begin
          if (mem_rdy) begin
            if (last) begin
              cnt   <= '0;
              state <= FILL_MEM;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FILL_MEM: begin
          // Return data is only meaningful while our single read is in flight.
          if (!rd_pend) begin
            if (mem_rdy) rd_pend <= 1'b1;
          end else if (mem_rvalid) begin
            rd_pend <= 1'b0;
            if (last) begin
              cnt   <= '0;
              state <= FILL_WR;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FILL_WR: begin
          if (last) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt     <= '0;
          rd_pend <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Line buffer holds either the victim (writeback) or the fill data.
  always_ff @(posedge clk) begin
    if (state == WB_CAP) begin
      line_buf[cnt] <= dwrite;
    end else if (state == FILL_MEM && rd_pend && mem_rvalid) begin
      line_buf[cnt] <= mem_rdata;
    end
  end

  always_comb begin
    rstrobe_d = (state == WB_CAP);
    wstrobe_d = (state == FILL_WR);
    dread     = wstrobe_d ? line_buf[cnt] : 4'h0;
    mem_valid = (state == WB_MEM) || (state == FILL_MEM && !rd_pend);
    mem_we    = (state == WB_MEM);
    mem_wdata = mem_we ? line_buf[cnt] : 4'h0;
    mem_addr  = '0;
    if (mem_valid) mem_addr = {(mem_we ? victim_tag_q : miss_tag_q), cnt};
    done      = (state == DONE);
    // IDLE term is gated so the CPU is released while reset is held.
    stall     = (state != IDLE) || (!reset && req && !hit && !fault);
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: IDLE vector table, then miss sequences scored
// against an expected queue of memory operations and cache write nibbles.
module tb_dcache_ctrl;
  localparam int PA = 22;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, hit, push, fault;
  logic [TW-1:0] miss_tag, victim_tag;
  logic [3:0]    dwrite;
  logic          rstrobe_d, wstrobe_d;
  logic [3:0]    dread;
  logic          stall, done;
  logic          mem_valid, mem_we;
  logic [PA:0]   mem_addr;
  logic [3:0]    mem_wdata;
  logic          mem_rdy, mem_rvalid;
  logic [3:0]    mem_rdata;
  logic [2:0]    state_dbg;

  dcache_ctrl #(.PA(PA), .LINE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .hit(hit), .push(push), .fault(fault),
    .miss_tag(miss_tag), .victim_tag(victim_tag), .dwrite(dwrite),
    .rstrobe_d(rstrobe_d), .wstrobe_d(wstrobe_d), .dread(dread),
    .stall(stall), .done(done), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: {we, addr, wdata (0 for reads)} and expected dread nibbles
  logic [27:0] exp_q[$];
  logic [3:0]  exp_dread_q[$];

  logic        rdy_random = 1'b0;
  logic [3:0]  rd_off = 4'h0;
  int          pend_cnt = 0;
  logic [3:0]  pend_data;
  int          r_cnt, w_cnt, r_runs, w_runs, done_cnt, stall_bad, mv_bad, both_bad;
  logic        prev_rs = 1'b0, prev_ws = 1'b0, prev_hold = 1'b0;
  logic [27:0] prev_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model + monitor, everything on the falling edge
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = 4'h0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
      end
    end else if (rdy_random && $urandom_range(0, 3) == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 4'hE;
    end
    mem_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;

    if (rstrobe_d) begin
      dwrite = 4'hF - 4'(r_cnt);
      r_cnt++;
      if (!prev_rs) r_runs++;
    end
    if (wstrobe_d) begin
      w_cnt++;
      if (!prev_ws) w_runs++;
      if (exp_dread_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dread: unexpected write nibble %0h", dread);
      end else begin
        check("dread", 32'(dread), 32'(exp_dread_q.pop_front()));
      end
    end
    if (rstrobe_d && wstrobe_d) both_bad++;
    if (done) done_cnt++;
    if (state_dbg != 3'd0 && !stall) stall_bad++;
    if (mem_valid && (rstrobe_d || wstrobe_d || done || state_dbg == 3'd0)) mv_bad++;
    prev_rs = rstrobe_d;
    prev_ws = wstrobe_d;

    if (prev_hold)
      check("hold_stable", {3'b0, mem_valid, mem_we, mem_addr, mem_wdata}, {4'b0001, prev_req});
    if (mem_valid && mem_rdy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL mem_op: unexpected op we=%0b addr=%0h", mem_we, mem_addr);
      end else begin
        check("mem_op", 32'({mem_we, mem_addr, mem_we ? mem_wdata : 4'h0}), 32'(exp_q.pop_front()));
      end
      if (!mem_we) begin
        pend_cnt  = 2;
        pend_data = 4'(mem_addr[2:0]) + 4'd1 + rd_off;
      end
    end
    prev_hold = mem_valid && !mem_rdy;
    prev_req  = {mem_we, mem_addr, mem_wdata};
  end

  // driver tasks
  task automatic start_miss(input logic [TW-1:0] mtag, input logic [TW-1:0] vtag,
                            input logic dirty, input logic rnd, input logic [3:0] off);
    rdy_random = rnd;
    rd_off     = off;
    r_cnt = 0; w_cnt = 0; r_runs = 0; w_runs = 0;
    done_cnt = 0; stall_bad = 0; mv_bad = 0; both_bad = 0;
    if (dirty)
      for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, vtag, 3'(k), 4'hF - 4'(k)});
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({1'b0, mtag, 3'(k), 4'h0});
      exp_dread_q.push_back(4'(k) + 4'd1 + off);
    end
    @(negedge clk); #1;
    req = 1'b1; hit = 1'b0; fault = 1'b0; push = dirty;
    miss_tag = mtag; victim_tag = vtag;
    #1 check("miss_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    // inputs wiggle while busy and must be ignored
    push = ~dirty; miss_tag = ~mtag; victim_tag = ~vtag;
  endtask

  task automatic finish_miss(input int exp_r);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    req = 1'b0;
    check("done_seen", 32'(done_cnt != 0), 32'd1);
    @(negedge clk); #1;
    check("back_idle", 32'(state_dbg), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("ops_left", 32'(exp_q.size()), 32'd0);
    check("dread_left", 32'(exp_dread_q.size()), 32'd0);
    check("rstrobe_cycles", 32'(r_cnt), 32'(exp_r));
    check("rstrobe_runs", 32'(r_runs), (exp_r != 0) ? 32'd1 : 32'd0);
    check("wstrobe_cycles", 32'(w_cnt), 32'd8);
    check("wstrobe_runs", 32'(w_runs), 32'd1);
    check("stall_low_busy", 32'(stall_bad), 32'd0);
    check("mem_valid_illegal", 32'(mv_bad), 32'd0);
    check("both_strobes", 32'(both_bad), 32'd0);
    exp_q.delete();
    exp_dread_q.delete();
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({stall, done, rstrobe_d, wstrobe_d, mem_valid, mem_we, mem_addr, mem_wdata, dread})
           ^ 32'(state_dbg);
  endfunction

  typedef struct {
    logic req, hit, push, fault, exp_stall;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; req = 1'b1; hit = 1'b0; push = 1'b0; fault = 1'b0;
    miss_tag = '0; victim_tag = '0; dwrite = 4'h0;
    mem_rdy = 1'b1; mem_rvalid = 1'b0; mem_rdata = 4'h0;
    #12;
    check("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;

    // IDLE decisions: hits and faults never leave IDLE
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = vecs[i].req; hit = vecs[i].hit; push = vecs[i].push; fault = vecs[i].fault;
      #1 check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      if (vecs[i].exp_stall) begin
        req = 1'b0;
      end else begin
        @(posedge clk); @(posedge clk); #1;
        check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'd0);
        check($sformatf("vec%0d_quiet", i), 32'({mem_valid, rstrobe_d, wstrobe_d, done}), 32'd0);
        req = 1'b0;
      end
    end
    hit = 1'b0; fault = 1'b0; push = 1'b0;

    // clean miss, then dirty miss with writeback ahead of fill
    start_miss(20'h01234, 20'h00ABC, 1'b0, 1'b0, 4'h0);
    finish_miss(0);
    start_miss(20'h00F0F, 20'h00ABC, 1'b1, 1'b0, 4'h3);
    finish_miss(8);

    // random back-pressure and stray return strobes
    for (int n = 0; n < 4; n++) begin
      start_miss(TW'($urandom_range(0, 20'hFFFFF)), TW'($urandom_range(0, 20'hFFFFF)),
                 1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)));
      finish_miss(r_runs != 0 ? 8 : 0);
    end

    // reset during the 4th cache write cycle
    start_miss(20'h05555, 20'h0AAAA, 1'b0, 1'b0, 4'h1);
    begin
      int t = 0;
      while (w_cnt < 4 && t < 500) begin
        @(negedge clk); #1;
        t++;
      end
    end
    check("wstrobe_before_reset", 32'(w_cnt), 32'd4);
    check("in_fill_wr", 32'(wstrobe_d), 32'd1);
    reset = 1'b1;
    #1 check("async_reset_outs", all_outs(), 32'd0);
    req = 1'b0;
    exp_q.delete();
    exp_dread_q.delete();
    pend_cnt = 0;
    repeat (2) @(negedge clk);
    #1 check("held_reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    start_miss(20'h0C3C3, 20'h01111, 1'b1, 1'b1, 4'h7);
    finish_miss(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
